// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial feeder for the bit-serial sequence detector.
// Words arrive over a valid/ready handshake into a one-entry holding register and
// are shifted out one bit per enabled cycle on dout.
// A word already waiting in the holding register is loaded the same edge the
// previous word's last bit is consumed, so consecutive words stream with no idle gap.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,     // word width, must be >= 2
    parameter bit MSB_FIRST = 1'b1,  // 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
    parameter bit IDLE_BIT  = 1'b0   // line level when no word is being shifted
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             bit_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   sh_reg;
    logic [WIDTH-1:0]   hold_reg;
    logic               hold_full_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [WIDTH-1:0]   sh_next;    // shift register after one bit leaves
    logic               out_bit;    // bit currently at the output end
    logic               in_shift;   // shifting and not being reset
    logic               last_bit;   // current bit is the word's final bit
    logic               accept;

    // Shift toward the output end; the vacated position takes the idle level so
    // the register never carries stale word bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign sh_next[gi] = IDLE_BIT;
                end else begin : g_move
                    assign sh_next[gi] = sh_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign sh_next[gi] = IDLE_BIT;
                end else begin : g_move
                    assign sh_next[gi] = sh_reg[gi+1];
                end
            end
        end

        if (MSB_FIRST) begin : g_out_msb
            assign out_bit = sh_reg[WIDTH-1];
        end else begin : g_out_lsb
            assign out_bit = sh_reg[0];
        end
    endgenerate

    // Output decode; reset forces the line idle in the reset cycle itself even
    // though the state registers only clear at the following edge.
    assign in_shift   = ~rst & (state_reg == SHIFT);
    assign last_bit   = (cnt_reg == LAST);
    assign dout       = in_shift ? out_bit : IDLE_BIT;
    assign dout_valid = in_shift & bit_en;
    assign word_done  = dout_valid & last_bit;
    assign busy       = ~rst & ((state_reg == SHIFT) | hold_full_reg);
    // Ready depends only on registered occupancy, never on the drain side.
    assign s_ready    = ~rst & ~hold_full_reg;
    assign accept     = s_valid & s_ready;

    // Holding-register fill plus IDLE/SHIFT sequencing of the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            hold_full_reg <= 1'b0;
            cnt_reg       <= '0;
            sh_reg        <= '0;
        end else begin
            // Accept only happens while the holding register is empty, and a
            // drain only while it is full, so these never collide.
            if (accept) begin
                hold_reg      <= s_data;
                hold_full_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (hold_full_reg) begin
                        sh_reg        <= hold_reg;
                        cnt_reg       <= '0;
                        hold_full_reg <= 1'b0;
                        state_reg     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        if (!last_bit) begin
                            sh_reg  <= sh_next;
                            cnt_reg <= cnt_reg + 1'b1;
                        end else if (hold_full_reg) begin
                            // Gapless hand-over to the waiting word.
                            sh_reg        <= hold_reg;
                            cnt_reg       <= '0;
                            hold_full_reg <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
